fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
- Write-side controller for the dual-clock FIFO memory.
- Sits between the producer and the FIFO memory write port, in the wrclk domain only.
- Accepts push requests and generates the memory write enable and write address.
- Exports a Gray-coded write pointer for the read domain; synchronizes the read domain's Gray pointer back to derive full, almost-full, fill level and a sticky overflow flag.

Parameters:
- ADDR_W, 7: memory address bits. DEPTH = 2**ADDR_W = 128. DEPTH must be a power of two; the parent instantiates the memory with depth = DEPTH.
- S, 8: width of wrptr, matching the memory pointer width. S >= ADDR_W.
- AF_THRESH, 120: almost_full asserts when level >= AF_THRESH. Legal range 1..DEPTH.

Ports:
- wrclk  in  1  write-domain clock; all state updates on its rising edge.
- wrrst  in  1  synchronous, active-high reset, sampled on wrclk.
- wr_req  in  1  producer push request for the current cycle.
- wr_din  in  8  producer data.
- ovf_clr  in  1  clears the overflow flag.
- rdptr_gray  in  ADDR_W+1  read pointer, Gray-coded, from the rdclk domain (asynchronous to wrclk).
- wren  out  1  memory write enable.
- wrptr  out  S  memory write address.
- wrdata  out  8  memory write data.
- wrptr_gray  out  ADDR_W+1  registered Gray write pointer, sent to the read domain.
- full  out  1  FIFO full, registered.
- almost_full  out  1  level >= AF_THRESH, registered.
- level  out  ADDR_W+1  entries in the FIFO as seen from the write side, registered.
- overflow  out  1  sticky; set by a push attempted while full.

Behaviour:
- Internal state:
  - wbin: ADDR_W+1-bit binary write pointer; MSB is the lap bit.
  - rs1, rs2: 2-flop synchronizer for rdptr_gray.
- Reset (wrrst=1 at an edge): wbin, rs1, rs2, wrptr_gray, level, full, almost_full and overflow all go to 0. Reset has priority over every other event.
- Combinational outputs:
  - push = wr_req & ~full.
  - wren = push.
  - wrdata = wr_din.
  - wrptr = wbin[ADDR_W-1:0], zero-extended to S bits.
  - The memory captures wrdata at the same edge at which wbin increments.
- Per edge, when not in reset:
  - wbin_n = wbin + push, modulo 2**(ADDR_W+1). Address wraps 127 -> 0 and the lap bit toggles.
  - wbin <= wbin_n.
  - wrptr_gray <= wbin_n ^ (wbin_n >> 1).
  - rs1 <= rdptr_gray; rs2 <= rs1.
  - rbin_n = gray-to-binary of rs1, i.e. the value rs2 takes at this edge.
  - lvl_n = (wbin_n - rbin_n) modulo 2**(ADDR_W+1).
  - level <= lvl_n; full <= (lvl_n == DEPTH); almost_full <= (lvl_n >= AF_THRESH).
- Flag timing:
  - Flags are consistent with wbin every cycle, with no bubble.
  - full asserts in the cycle right after the push that fills the FIFO.
- Read-pointer latency: a change on rdptr_gray set up before edge E1 is captured into rs1 at E1. level, full and almost_full reflect it after E2 (2 wrclk edges).
- Overflow:
  - Set when wr_req=1 and full=1 at an edge.
  - Priority order: reset, then set, then ovf_clr (clears only if not being set in that cycle).
  - A push attempted while full drops the data: no wren, no pointer change.
- Simultaneous events:
  - A push on the same edge as a read-side release: both apply, and lvl_n is computed from both.
  - When full, a release on rdptr_gray does not enable a push until full deasserts (after E2).
- Level never exceeds DEPTH given a legal read side. rdptr_gray must change by at most one Gray step per rdclk.

Test Plan:
- Reset: drive wrrst=1 for 2 edges with wr_req=1 and rdptr_gray=8'h55 -> all registered outputs 0, wrptr=0. wren follows wr_req while full=0.
- Fill: rdptr_gray=0, wr_req=1 for 130 cycles with wr_din=index ->
  - wren high for exactly 128 cycles at wrptr 0..127.
  - almost_full high after the 120th push.
  - full high after the 128th push; level=128; wrptr_gray=8'hC0.
  - overflow set after the 129th attempt; wrptr stays 0.
- Release latency: while full, set rdptr_gray 0->1 before edge E1 -> full low and level=127 after E1+1 edge. The next wr_req pushes at wrptr=0 with the lap bit set.
- Wrap: run continuous push with a read pointer trailing 4 entries for 300 pushes -> wrptr wraps 127->0. wrptr_gray changes exactly one bit per push. level stays 4 or 5, full never asserts.
- Overflow clear: with overflow=1, pulse ovf_clr with wr_req=0 -> overflow=0. Repeat with wr_req=1 and full=1 -> overflow stays 1.
- Mid-operation reset: with level=60, assert wrrst for one edge -> all state 0. The first push after reset uses wrptr=0.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_ctrl
// Brief   : Write-side controller of a dual-clock FIFO. It generates the write
//           enable and address and exports a Gray write pointer. The read
//           pointer is brought into wrclk to derive level/full/almost_full/overflow.
// Rev     : 1.0  initial release
// ============================================================================
module fifo_wr_ctrl #(
    parameter int ADDR_W    = 7,
    parameter int S         = 8,
    parameter int AF_THRESH = 120
) (
    input  logic              wrclk,
    input  logic              wrrst,
    input  logic              wr_req,
    input  logic [7:0]        wr_din,
    input  logic              ovf_clr,
    input  logic [ADDR_W:0]   rdptr_gray,
    output logic              wren,
    output logic [S-1:0]      wrptr,
    output logic [7:0]        wrdata,
    output logic [ADDR_W:0]   wrptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] C_AF    = (ADDR_W+1)'(AF_THRESH);

    logic [ADDR_W:0] wbin_q, wbin_d;
    logic [ADDR_W:0] rs1_q;
    logic [ADDR_W:0] gray_q, gray_d;
    logic [ADDR_W:0] level_q, lvl_d;
    logic            full_q, full_d;
    logic            af_q, af_d;
    logic            ovf_q, ovf_d;
    logic [ADDR_W:0] rbin;
    logic            push;

    assign push   = wr_req & ~full_q;
    assign wren   = push;
    assign wrdata = wr_din;
    assign wrptr  = S'(wbin_q[ADDR_W-1:0]);

    // The level/full/almost_full registers act as the second synchronizer
    // stage: they capture the binary form of the first-stage Gray sample.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rbin[i] = ^(rs1_q >> i);
        end
    end

    always_comb begin
        wbin_d = wbin_q + {{ADDR_W{1'b0}}, push};
        gray_d = wbin_d ^ (wbin_d >> 1);
        lvl_d  = wbin_d - rbin;
        full_d = (lvl_d == C_DEPTH);
        af_d   = (lvl_d >= C_AF);
        ovf_d  = ovf_q;
        if (wr_req && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge wrclk) begin
        if (wrrst) begin
            wbin_q  <= '0;
            rs1_q   <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            rs1_q   <= rdptr_gray;
            gray_q  <= gray_d;
            level_q <= lvl_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wrptr_gray  = gray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign level       = level_q;
    assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_wr_ctrl
// Brief   : Directed bench for fifo_wr_ctrl with a write scoreboard and a
//           cycle model of the write-side flags.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fifo_wr_ctrl;

    logic       wrclk = 1'b0;
    logic       wrrst, wr_req, ovf_clr;
    logic [7:0] wr_din, rdptr_gray;
    logic       wren, full, almost_full, overflow;
    logic [7:0] wrptr, wrdata, wrptr_gray, level;

    int vectors     = 0;
    int miscompares = 0;
    int wren_count  = 0;

    logic [15:0] sb[$];

    logic [7:0] m_wbin, m_rs1, m_gray, m_level;
    logic       m_full, m_af, m_ovf;

    fifo_wr_ctrl #(.ADDR_W(7), .S(8), .AF_THRESH(120)) dut (
        .wrclk(wrclk), .wrrst(wrrst), .wr_req(wr_req), .wr_din(wr_din),
        .ovf_clr(ovf_clr), .rdptr_gray(rdptr_gray), .wren(wren), .wrptr(wrptr),
        .wrdata(wrdata), .wrptr_gray(wrptr_gray), .full(full),
        .almost_full(almost_full), .level(level), .overflow(overflow)
    );

    always #5 wrclk = ~wrclk;

    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [7:0] b2g(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One wrclk cycle: drive, check combinational write port, clock, check flags.
    task automatic cyc(input logic rst, input logic req, input logic [7:0] din,
                       input logic clr, input logic [7:0] rdg);
        logic       m_push;
        logic [7:0] wn, rb, lv;
        logic [15:0] e;
        wrrst = rst; wr_req = req; wr_din = din; ovf_clr = clr; rdptr_gray = rdg;
        #1;
        m_push = req & ~m_full;
        if (m_push) sb.push_back({1'b0, m_wbin[6:0], din});
        chk("wren", wren, m_push);
        if (wren === 1'b1) begin
            wren_count++;
            if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
            else begin
                e = sb.pop_front();
                chk("wr_addr_data", {wrptr, wrdata}, e);
            end
        end
        @(posedge wrclk);
        if (rst) begin
            m_wbin = 0; m_rs1 = 0; m_gray = 0; m_level = 0;
            m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            wn = m_wbin + {7'd0, m_push};
            rb = g2b(m_rs1);
            lv = wn - rb;
            if (req && m_full) m_ovf = 1'b1;
            else if (clr)      m_ovf = 1'b0;
            m_wbin = wn; m_gray = b2g(wn); m_rs1 = rdg; m_level = lv;
            m_full = (lv == 8'd128); m_af = (lv >= 8'd120);
        end
        #1;
        chk("wrptr_gray", wrptr_gray, m_gray);
        chk("level", level, m_level);
        chk("full", full, m_full);
        chk("almost_full", almost_full, m_af);
        chk("overflow", overflow, m_ovf);
    endtask

    initial begin
        logic [7:0] prev_gray, prev_ptr, rd;
        logic       seen_wrap;
        wrrst = 1'b1; wr_req = 1'b1; wr_din = 8'h00; ovf_clr = 1'b0; rdptr_gray = 8'h55;
        @(posedge wrclk); #1;
        m_wbin = 0; m_rs1 = 0; m_gray = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;

        // reset, second edge, with push request and junk read pointer
        cyc(1'b1, 1'b1, 8'h00, 1'b0, 8'h55);
        chk("rst_wrptr", wrptr, 8'd0);
        chk("rst_level", level, 8'd0);
        chk("rst_full", full, 1'b0);
        wren_count = 0;

        // fill
        for (int i = 0; i < 130; i++) begin
            cyc(1'b0, 1'b1, 8'(i), 1'b0, 8'h00);
            if (i == 118) chk("af_before_120", almost_full, 1'b0);
            if (i == 119) chk("af_at_120", almost_full, 1'b1);
            if (i == 126) chk("full_before_128", full, 1'b0);
            if (i == 127) begin
                chk("full_at_128", full, 1'b1);
                chk("level_128", level, 8'd128);
                chk("gray_c0", wrptr_gray, 8'hC0);
                chk("ovf_not_yet", overflow, 1'b0);
            end
            if (i == 128) chk("ovf_129th", overflow, 1'b1);
        end
        chk("fill_wren_count", wren_count, 128);
        chk("fill_wrptr_stays", wrptr, 8'd0);

        // read-side release latency
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h01);
        chk("rel_e1_full", full, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h01);
        chk("rel_e2_full", full, 1'b0);
        chk("rel_e2_level", level, 8'd127);
        chk("rel_push_wrptr", wrptr, 8'd0);
        cyc(1'b0, 1'b1, 8'hAA, 1'b0, 8'h01);
        chk("rel_push_gray", wrptr_gray, 8'hC1);
        chk("rel_push_full", full, 1'b1);

        // overflow clear
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h01);
        chk("ovf_clr", overflow, 1'b0);
        cyc(1'b0, 1'b1, 8'h11, 1'b0, 8'h01);
        chk("ovf_reset", overflow, 1'b1);
        cyc(1'b0, 1'b1, 8'h22, 1'b1, 8'h01);
        chk("ovf_set_beats_clr", overflow, 1'b1);

        // mid-operation reset at level 60
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, 8'(i + 8'h40), 1'b0, 8'h00);
        chk("mid_level_60", level, 8'd60);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("mid_rst_level", level, 8'd0);
        chk("mid_rst_gray", wrptr_gray, 8'd0);
        chk("mid_rst_wrptr", wrptr, 8'd0);
        cyc(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00);
        chk("post_rst_level", level, 8'd1);

        // wrap with read pointer trailing
        seen_wrap = 1'b0;
        for (int n = 0; n < 300; n++) begin
            prev_gray = wrptr_gray;
            prev_ptr  = wrptr;
            rd = (n >= 2) ? b2g(m_wbin - 8'd3) : 8'h00;
            cyc(1'b0, 1'b1, 8'(n), 1'b0, rd);
            chk("wrap_gray_1bit", $countones(prev_gray ^ wrptr_gray), 1);
            if (prev_ptr == 8'd127 && wrptr == 8'd0) seen_wrap = 1'b1;
            if (n >= 8) chk("wrap_level_4_5", (level == 8'd4 || level == 8'd5), 1'b1);
        end
        chk("wrap_seen", seen_wrap, 1'b1);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
